window_buffer_2d: RTL and testbench

Streaming 2D sliding-window generator for the HOG front end. It takes a raster-order pixel stream and emits one KERNEL_H×KERNEL_W window per accepted pixel once the window lies fully inside the image. It uses KERNEL_H-1 line buffers plus a column shift register, with valid/ready backpressure, row-boundary suppression, and frame wrap. It supersedes the 1D kernel shift register between the pixel source and the gradient/convolution stages.

---
 rtl/window_buffer_2d_pkg.sv | 23 ++
 rtl/window_buffer_2d_line_buffer.sv | 32 +++
 rtl/window_buffer_2d.sv | 184 ++++++++++++++++++
 tb/tb_window_buffer_2d.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_buffer_2d_pkg.sv
// hog_window_pkg: shared types and helpers for the 2D sliding-window generator.
//   state_t     - window generator phase (line buffers filling / windows streaming)
//   cnt_width   - bit width of a counter or address covering 0..n-1 (minimum 1)
//   win_offset  - bit offset of window element (r,c) in the flattened window bus
package hog_window_pkg;

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned win_offset(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned kw,
                                             input int unsigned dw);
    return (r * kw + c) * dw;
  endfunction

endpackage

// File: rtl/window_buffer_2d_line_buffer.sv
// line_buffer: one image row of pixel storage with a single address port.
// The read is asynchronous, so during a write cycle rd_data still shows the
// word being replaced (read-before-write). Contents are never reset.
//   clk     - clock
//   we      - write enable (pixel handshake)
//   addr    - column address, shared by read and write
//   wr_data - word written at addr on the rising edge when we=1
//   rd_data - word currently stored at addr
module line_buffer
  import hog_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [cnt_width(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/window_buffer_2d.sv
// window_buffer_2d: streaming KERNEL_H x KERNEL_W sliding-window generator.
// Accepts a raster-order pixel stream and emits one window per accepted pixel
// once the window lies fully inside the image (no row straddling).
//   clk, rst   - clock and synchronous active-high reset
//   in_data    - pixel, raster order
//   in_valid   - pixel present
//   in_ready   - pixel accepted when in_valid && in_ready
//   out_data   - window, element (r,c) at [(r*KERNEL_W+c)*DATA_WIDTH +: DATA_WIDTH],
//                r=0 oldest row, c=0 leftmost column (newest pixel in the MSBs)
//   out_valid  - window present
//   out_ready  - downstream accepts window
//   out_last   - window whose newest pixel is the last pixel of the frame
module window_buffer_2d
  import hog_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KERNEL_W   = 3,
  parameter int unsigned KERNEL_H   = 3,
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [DATA_WIDTH*KERNEL_W*KERNEL_H-1:0]  out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last
);

  localparam int unsigned CW = cnt_width(IMG_W);
  localparam int unsigned RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam bit MULTI_ROW = (KERNEL_H > 1);
  // Last row that only fills the line buffers.
  localparam logic [RW-1:0] FILL_LAST_ROW = RW'(MULTI_ROW ? KERNEL_H - 2 : 0);
  localparam state_t S_INIT = MULTI_ROW ? S_FILL : S_STREAM;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            hs;
  logic            col_ok;
  logic            eligible;
  logic            row_end;
  logic            frame_end;

  logic [DATA_WIDTH-1:0] new_col [KERNEL_H];
  logic [DATA_WIDTH-1:0] win     [KERNEL_H][KERNEL_W];

  // ---------------------------------------------------------------- control
  assign row_end   = (col == COL_MAX);
  assign frame_end = row_end && (row == ROW_MAX);

  if (KERNEL_W > 1) begin : g_col_chk
    assign col_ok = (col >= CW'(KERNEL_W - 1));
  end else begin : g_col_any
    assign col_ok = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (hs && row_end && (row == FILL_LAST_ROW)) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs && frame_end && MULTI_ROW) begin
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Output/handshake decode
  always_comb begin
    in_ready = out_ready || !out_valid;
    hs       = in_valid && in_ready;
    eligible = (state == S_STREAM) && col_ok;
  end

  // Raster counters and the single-stage output register flags
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (in_ready) begin
        out_valid <= hs && eligible;
        out_last  <= hs && eligible && frame_end;
      end
      if (hs) begin
        if (row_end) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // ----------------------------------------------------------- line buffers
  // Buffer k holds the row k+1 above the incoming one: buffer 0 is written
  // with the new pixel, each later buffer with the word its predecessor is
  // about to lose, so the whole column shifts up one row per handshake.
  if (MULTI_ROW) begin : g_lines
    logic [DATA_WIDTH-1:0] lb_rd [KERNEL_H-1];

    for (genvar k = 0; k < KERNEL_H - 1; k++) begin : g_lb
      logic [DATA_WIDTH-1:0] wr;

      if (k == 0) begin : g_head
        assign wr = in_data;
      end else begin : g_tail
        assign wr = lb_rd[k-1];
      end

      line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
      ) u_line (
        .clk     (clk),
        .we      (hs),
        .addr    (col),
        .wr_data (wr),
        .rd_data (lb_rd[k])
      );

      assign new_col[KERNEL_H-2-k] = lb_rd[k];
    end
  end

  assign new_col[KERNEL_H-1] = in_data;

  // ------------------------------------------------------ window shift reg
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < KERNEL_H; r++) begin
        for (int unsigned c = 0; c < KERNEL_W; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (hs) begin
      for (int unsigned r = 0; r < KERNEL_H; r++) begin
        for (int unsigned c = 0; c + 1 < KERNEL_W; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][KERNEL_W-1] <= new_col[r];
      end
    end
  end

  // The shift register only moves on a handshake, which cannot happen while
  // a window is stalled, so it doubles as the output data register.
  always_comb begin
    out_data = '0;
    for (int unsigned r = 0; r < KERNEL_H; r++) begin
      for (int unsigned c = 0; c < KERNEL_W; c++) begin
        out_data[win_offset(r, c, KERNEL_W, DATA_WIDTH) +: DATA_WIDTH] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_buffer_2d.sv
module tb_window_buffer_2d;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int OW = DW * 9;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    int            fid;
    int            x;
    int            y;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] in_data1;
  logic          in_valid1;
  logic          in_ready1;
  logic [DW-1:0] out_data1;
  logic          out_valid1;
  logic          out_ready1;
  logic          out_last1;

  int            n_tests = 0;
  int            n_fail  = 0;
  exp_t          q[$];
  exp_t          q1[$];
  logic [DW-1:0] img [IH][IW];
  int            mx = 0;
  int            my = 0;
  bit            m_ov = 1'b0;
  bit            last_hs;
  int            cur_fid;
  int            n_win [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  window_buffer_2d #(
    .DATA_WIDTH (DW),
    .KERNEL_W   (3),
    .KERNEL_H   (3),
    .IMG_W      (IW),
    .IMG_H      (IH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  window_buffer_2d #(
    .DATA_WIDTH (DW),
    .KERNEL_W   (1),
    .KERNEL_H   (1),
    .IMG_W      (IW),
    .IMG_H      (IH)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_data  (out_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_last  (out_last1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form window for a frame whose pixel (x,y) holds base + 8*y + x.
  function automatic logic [OW-1:0] win_from(input int base, input int x, input int y);
    logic [OW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3+c)*DW +: DW] = 8'(base + 8 * (y - 2 + r) + (x - 2 + c));
      end
    end
    return w;
  endfunction

  // One clock of the 3x3 instance: check outputs at the falling edge, update
  // the scoreboard for the coming rising edge, return at posedge+1.
  task automatic cycle(input bit in_rst);
    exp_t e;
    bit   hs;
    bit   elig;
    @(negedge clk);
    if (!in_rst) begin
      chk("in_ready", in_ready, out_ready || !m_ov);
      chk("out_valid", out_valid, m_ov);
      if (out_valid) begin
        chk("spurious_window", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q[0];
          chk($sformatf("win f%0d (%0d,%0d)", e.fid, e.x, e.y), out_data, e.data);
          chk($sformatf("last f%0d (%0d,%0d)", e.fid, e.x, e.y), out_last, e.last);
          if (out_ready) begin
            void'(q.pop_front());
            n_win[e.fid]++;
            if (e.x == 2 && e.y == 2 && e.fid != 2) begin
              chk("first_window", out_data, win_from(e.fid == 1 ? 100 : 0, 2, 2));
            end
            if (e.fid == 0 && e.x == 2 && e.y == 2) begin
              chk("first_window_msb", out_data[OW-1 -: DW], 18);
            end
            if (e.fid == 0 && e.x == 2 && e.y == 4) begin
              chk("row4_window", out_data, win_from(0, 2, 4));
            end
          end
        end
      end
    end
    hs = in_valid && in_ready;
    last_hs = hs;
    if (in_rst) begin
      q.delete();
      m_ov = 1'b0;
      mx = 0;
      my = 0;
    end else begin
      elig = hs && mx >= 2 && my >= 2;
      if (hs) begin
        img[my][mx] = in_data;
        if (elig) begin
          e.data = '0;
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              e.data[(r*3+c)*DW +: DW] = img[my-2+r][mx-2+c];
            end
          end
          e.last = (mx == IW - 1) && (my == IH - 1);
          e.fid  = cur_fid;
          e.x    = mx;
          e.y    = my;
          q.push_back(e);
        end
        if (mx == IW - 1) begin
          mx = 0;
          my = (my == IH - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      if (out_ready || !m_ov) m_ov = elig;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0);
      if (last_hs) break;
    end
    chk("pixel_accepted", last_hs, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_in_ready1"}, in_ready1, 1);
    chk({tag, "_out_valid1"}, out_valid1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    in_valid1 = 1'b0;
    in_data1 = '0;
    out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Frame 0: steady stream with occasional idle input cycles.
    cur_fid = 0;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        send(8'(8 * y + x));
        if ((8 * y + x) % 5 == 4) begin
          in_valid = 1'b0;
          cycle(1'b0);
        end
      end
    end

    // Frame 1 back-to-back, with a 5-cycle downstream stall mid-row 3.
    cur_fid = 1;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        if (y == 3 && x == 4) begin
          in_valid  = 1'b1;
          in_data   = 8'(100 + 8 * y + x);
          out_ready = 1'b0;
          repeat (5) begin
            cycle(1'b0);
            chk("stall_no_accept", last_hs, 0);
          end
          out_ready = 1'b1;
        end
        send(8'(100 + 8 * y + x));
      end
    end
    in_valid = 1'b0;
    repeat (3) cycle(1'b0);

    // Frame 2: reset after pixel (4,3).
    cur_fid = 2;
    for (int p = 0; p <= 3 * IW + 4; p++) begin
      send(8'(50 + p));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    check_reset("midrst");

    // Frame 3: full frame after reset.
    cur_fid = 3;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        send(8'(8 * y + x));
      end
    end
    in_valid = 1'b0;
    repeat (3) cycle(1'b0);

    chk("frame0_windows", n_win[0], 24);
    chk("frame1_windows", n_win[1], 24);
    chk("frame2_windows", n_win[2], 8);
    chk("frame3_windows", n_win[3], 24);
    chk("scoreboard_empty", q.size(), 0);

    // Degenerate 1x1 kernel: every pixel is its own window, 1-cycle latency.
    for (int p = 0; p <= IW * IH; p++) begin
      in_valid1 = (p < IW * IH);
      in_data1  = 8'(p * 5 + 3);
      @(negedge clk);
      chk("deg_out_valid", out_valid1, q1.size() != 0);
      if (out_valid1 && q1.size() != 0) begin
        e1 = q1.pop_front();
        chk($sformatf("deg_data p%0d", e1.x), out_data1, e1.data);
        chk($sformatf("deg_last p%0d", e1.x), out_last1, e1.last);
      end
      if (in_valid1) begin
        chk("deg_in_ready", in_ready1, 1);
        e1.data = '0;
        e1.data[DW-1:0] = in_data1;
        e1.last = (p == IW * IH - 1);
        e1.fid  = 0;
        e1.x    = p;
        e1.y    = 0;
        q1.push_back(e1);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("deg_idle", out_valid1, 0);
    chk("deg_scoreboard_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
